// File: rtl/uart_rx_multi.sv
// UART receiver with runtime framing (baud, data width, parity, stop bits),
// 3-sample majority voting, break detection and a small output frame FIFO.
module uart_rx_multi #(
    parameter int MAX_DATA_BITS = 9,
    parameter int DIV_WIDTH     = 16,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rx,
    input  logic [DIV_WIDTH-1:0]     baud_div,
    input  logic [3:0]               data_bits,
    input  logic [1:0]               parity_type,
    input  logic                     stop2,
    input  logic                     rx_ready,
    output logic                     rx_valid,
    output logic [MAX_DATA_BITS-1:0] rx_data,
    output logic                     rx_parity_err,
    output logic                     rx_frame_err,
    output logic                     overrun,
    output logic                     break_det
);
    localparam int EW = MAX_DATA_BITS + 2;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [DIV_WIDTH-1:0] NMIN = DIV_WIDTH'(4);
    localparam logic [3:0]           DMAX = 4'(MAX_DATA_BITS);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2, BREAK_WAIT} state_t;
    state_t state, state_nx;

    logic r1, rxs, rxs_d, armed;
    logic [DIV_WIDTH-1:0]     n_r, cnt, mid;
    logic [3:0]               db_r, idx;
    logic                     pen, podd, st2;
    logic                     s0, s1, pbit, sbit, perr, ferr;
    logic [MAX_DATA_BITS-1:0] data;
    logic                     start_det, dec, wrap, bit_now, stop_first, is_brk, ferr_c;
    logic                     push, brk;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r1 <= 1'b1; rxs <= 1'b1; rxs_d <= 1'b1; armed <= 1'b0;
        end else begin
            r1 <= rx; rxs <= r1; rxs_d <= rxs;
            if (rxs) armed <= 1'b1;
        end
    end

    assign start_det  = armed && state == IDLE && rxs_d && !rxs;
    assign mid        = n_r >> 1;
    assign dec        = cnt == mid + DIV_WIDTH'(1);
    assign wrap       = cnt == n_r - DIV_WIDTH'(1);
    assign bit_now    = (s0 & s1) | (s0 & rxs) | (s1 & rxs);
    assign stop_first = (state == STOP1) ? bit_now : sbit;
    assign is_brk     = data == '0 && (!pen || !pbit) && !stop_first;
    assign ferr_c     = ferr | ~bit_now;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        push     = 1'b0;
        brk      = 1'b0;
        case (state)
            IDLE:   if (start_det) state_nx = START;
            START:  if (dec && bit_now) state_nx = IDLE;
                    else if (wrap) state_nx = DATA;
            DATA:   if (wrap && idx == db_r - 4'd1) state_nx = pen ? PARITY : STOP1;
            PARITY: if (wrap) state_nx = STOP1;
            STOP1:  if (dec && !st2) begin
                        if (is_brk) begin brk = 1'b1; state_nx = BREAK_WAIT; end
                        else begin push = 1'b1; state_nx = IDLE; end
                    end else if (wrap && st2) state_nx = STOP2;
            STOP2:  if (dec) begin
                        if (is_brk) begin brk = 1'b1; state_nx = BREAK_WAIT; end
                        else begin push = 1'b1; state_nx = IDLE; end
                    end
            BREAK_WAIT: if (rxs) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Frame settings are captured at the start edge so mid-frame changes are ignored.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            n_r <= NMIN; db_r <= 4'd5; pen <= 1'b0; podd <= 1'b0; st2 <= 1'b0;
            cnt <= '0; idx <= '0; data <= '0; s0 <= 1'b1; s1 <= 1'b1;
            pbit <= 1'b0; sbit <= 1'b1; perr <= 1'b0; ferr <= 1'b0;
        end else if (start_det) begin
            n_r  <= (baud_div < NMIN) ? NMIN : baud_div;
            db_r <= (data_bits < 4'd5) ? 4'd5 : (data_bits > DMAX) ? DMAX : data_bits;
            pen  <= parity_type == 2'd1 || parity_type == 2'd2;
            podd <= parity_type == 2'd2;
            st2  <= stop2;
            cnt <= '0; idx <= '0; data <= '0; perr <= 1'b0; ferr <= 1'b0;
        end else if (state != IDLE && state != BREAK_WAIT) begin
            cnt <= wrap ? '0 : cnt + DIV_WIDTH'(1);
            if (cnt == mid - DIV_WIDTH'(1)) s0 <= rxs;
            if (cnt == mid) s1 <= rxs;
            if (dec) begin
                case (state)
                    DATA:   data[idx] <= bit_now;
                    PARITY: begin pbit <= bit_now; perr <= (^data) ^ bit_now ^ podd; end
                    STOP1:  begin sbit <= bit_now; ferr <= ferr_c; end
                    STOP2:  ferr <= ferr_c;
                    default: ;
                endcase
            end
            if (wrap && state == DATA) idx <= idx + 4'd1;
        end
    end

    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [CW-1:0] count;
    logic          full, pop, accept;
    logic [EW-1:0] head;

    assign full   = count == CW'(FIFO_DEPTH);
    assign pop    = rx_valid & rx_ready;
    assign accept = push & (!full | pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wptr <= '0; rptr <= '0; count <= '0; overrun <= 1'b0; break_det <= 1'b0;
        end else begin
            if (accept) begin
                mem[wptr] <= {ferr_c, perr, data};
                wptr      <= wptr + AW'(1);
            end
            if (pop) rptr <= rptr + AW'(1);
            case ({accept, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
            overrun   <= push & full & !pop;
            break_det <= brk;
        end
    end

    assign head          = mem[rptr];
    assign rx_valid      = count != '0;
    assign rx_data       = head[MAX_DATA_BITS-1:0];
    assign rx_parity_err = head[MAX_DATA_BITS];
    assign rx_frame_err  = head[MAX_DATA_BITS+1];
endmodule
